// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial WIDTH-bit adder sharing one full adder cell, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module better_full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_opa, r_opb, r_psum, r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry, r_cout;
    logic             w_s, w_cout, w_load, w_last;

    better_full_adder u_fa (
        .a    (r_opa[0]),
        .b    (r_opb[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_last = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_load = start;
                w_next = start ? S_RUN : S_IDLE;
            end
            S_RUN: begin
                w_last = (r_cnt == CW'(WIDTH - 1));
                w_next = w_last ? S_DONE : S_RUN;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Partial sum fills from the MSB so after WIDTH shifts bit 0 holds the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opa   <= '0;
            r_opb   <= '0;
            r_psum  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_opa   <= a;
            r_opb   <= b;
            r_carry <= cin;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_opa   <= r_opa >> 1;
            r_opb   <= r_opb >> 1;
            r_psum  <= {w_s, r_psum[WIDTH-1:1]};
            r_carry <= w_cout;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_last) begin
            r_sum  <= {w_s, r_psum[WIDTH-1:1]};
            r_cout <= w_cout;
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // r_carry in the last RUN cycle is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (rst)         r_ovf <= 1'b0;
        else if (w_last) r_ovf <= r_carry ^ w_cout;
    end

    assign ovf = r_ovf;
`endif

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: table-driven and randomized checks of serial_adder_ctrl (WIDTH=8)
// against an arithmetic reference, with per-cycle done-pulse and output-stability monitoring.
module tb_serial_adder_ctrl;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, start, cin;
    logic [W-1:0] a, b;
    logic         busy, done, cout;
    logic [W-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] esum;
        logic         ecout;
    } vec_t;

    vec_t         vecs[7];
    int           n_checks = 0;
    int           n_fail = 0;
    int           done_pulses = 0;
    bit           mon_en = 1'b0;
    logic         prev_done, prev_cout;
    logic [W-1:0] prev_sum;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Every clock advance goes through here so the per-cycle monitor never misses a cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (mon_en) begin
            chk("done_single_cycle", {31'b0, done & prev_done}, 32'd0);
            if (busy) begin
                chk("sum_stable_busy", {24'b0, sum}, {24'b0, prev_sum});
                chk("cout_stable_busy", {31'b0, cout}, {31'b0, prev_cout});
            end
            if (done) done_pulses++;
        end
        prev_done = done;
        prev_sum  = sum;
        prev_cout = cout;
    endtask

    task automatic run_add(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                           input logic [W-1:0] es, input logic ec, input bit noise);
        int k, nb, d0;
        a = ta; b = tb_; cin = tc; start = 1'b1;
        step();
        start = 1'b0;
        d0 = done_pulses; k = 0; nb = 0;
        while (!done && k < 30) begin
            if (busy) nb++;
            if (noise) begin
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom); start = 1'($urandom);
            end
            step();
            k++;
        end
        start = 1'b0;
        chk("done_latency", k, W);
        chk("busy_cycles", nb, W);
        chk("sum", {24'b0, sum}, {24'b0, es});
        chk("cout", {31'b0, cout}, {31'b0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        begin
            int s;
            s = int'($signed(ta)) + int'($signed(tb_)) + int'(tc);
            chk("ovf", {31'b0, ovf}, {31'b0, (s > 127 || s < -128)});
        end
`endif
        step();
        chk("done_pulse_count", done_pulses - d0, 1);
        chk("idle_after_done", {30'b0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc;
        logic [W:0]   r;
        int           d0;

        vecs[0] = '{8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};

        rst = 1'b1; start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b1;
        step();
        step();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum", {24'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
`endif
        rst = 1'b0; start = 1'b0;
        mon_en = 1'b1;
        step();
        chk("no_start_after_rst", {30'b0, busy, done}, 32'd0);

        for (int i = 0; i < 7; i++)
            run_add(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].esum, vecs[i].ecout, 1'b0);

        // Start re-pulsed and operands scrambled throughout RUN must not disturb the result.
        run_add(8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 1'b1);

        for (int i = 0; i < 16; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            r = {1'b0, ra} + {1'b0, rb} + (W + 1)'(rc);
            run_add(ra, rb, rc, r[W-1:0], r[W], i[0]);
        end

        // Reset on the 4th RUN cycle aborts the add and clears the result registers.
        run_add(8'hC3, 8'h5A, 1'b1, 8'h1E, 1'b1, 1'b0);
        a = 8'h0F; b = 8'hF0; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        chk("busy_before_abort", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_sum", {24'b0, sum}, 32'd0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        d0 = done_pulses;
        repeat (12) step();
        chk("abort_no_done", done_pulses - d0, 0);
        run_add(8'h0F, 8'hF0, 1'b1, 8'h00, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
